pll_startup_seq: RTL
====================

# pll_startup_seq

Power-up and relock sequencer for the phase-sync PLL digital core. After the chip-level reset is released and `EN` is asserted, it:
- holds the loop sub-blocks in reset for a programmable time;
- launches the DCO calibration and waits for its completion handshake;
- closes the loop and waits for a qualified lock.

It then reports `READY`, or `FAIL` if either wait times out. It sits between the reset generator outputs and the calibration/loop-filter blocks.

## Interface
- `CNT_W`, 8: width of the programmable hold and lock-qualify counters.
- `TO_CYC`, 1023: timeout, in CLK cycles, for the CAL and LOCKWAIT states. Legal range 1..65535. The timeout counter is 16 bits.
- `CLK` input 1: system clock. All flops update on the rising edge.
- `NARST` input 1: asynchronous reset, active low. Assertion is asynchronous. Release is expected to be already synchronized upstream.
- `EN` input 1: sequence enable. A level signal, sampled every cycle.
- `T_HOLD` input CNT_W: sub-block reset hold time in cycles. 0 is treated as 1.
- `T_LOCK` input CNT_W: consecutive synchronized-lock cycles required. 0 is treated as 1.
- `CAL_DONE` input 1: calibration complete. Synchronous to CLK, level.
- `LOCK_DET` input 1: raw lock detector output. Asynchronous; synchronized internally.
- `NRST_SUB` output 1: active-low reset to the loop sub-blocks.
- `CAL_START` output 1: one-cycle calibration start pulse.
- `LOOP_EN` output 1: closes the loop.
- `READY` output 1: PLL locked and qualified.
- `FAIL` output 1: sticky timeout flag.
- `STATE` output 3: current state code, for debug.

## Operation
- States and encodings: IDLE=0, HOLD=1, CAL=2, LOCKWAIT=3, LOCKED=4, FAIL=5. Codes 6 and 7 are illegal and go to IDLE on the next cycle.
- Reset (`NARST`=0):
  - state is IDLE;
  - all outputs are 0, with `NRST_SUB`=0, so the sub-blocks are held in reset;
  - all counters and the synchronizer flops are 0.
- `EN`=0 in any state: the next state is IDLE. This has priority over every other transition.
- IDLE:
  - All outputs 0.
  - If `EN`=1, go to HOLD and load the hold counter with max(`T_HOLD`,1).
- HOLD:
  - `NRST_SUB`=0.
  - The hold counter decrements each cycle.
  - When the counter reaches 1, go to CAL.
- CAL:
  - `NRST_SUB`=1.
  - `CAL_START`=1 only in the first cycle after entry.
  - The timeout counter clears on entry and increments each cycle.
  - If `CAL_DONE`=1, go to LOCKWAIT.
  - Otherwise, when the timeout counter reaches `TO_CYC`-1, go to FAIL.
  - If `CAL_DONE` and the timeout occur in the same cycle, `CAL_DONE` wins.
- LOCKWAIT:
  - `LOOP_EN`=1.
  - The timeout counter clears on entry.
  - The qualify counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - When the qualify count reaches max(`T_LOCK`,1), go to LOCKED.
  - Otherwise, on timeout (`TO_CYC` cycles in this state), go to FAIL. The lock qualification wins a same-cycle tie.
- LOCKED:
  - `LOOP_EN`=1 and `READY`=1.
  - If `lock_s`=0, go to LOCKWAIT for relock. `READY` drops on that transition edge, and no recalibration is performed.
- FAIL:
  - `FAIL`=1, `LOOP_EN`=0, `NRST_SUB`=1.
  - The only exit is `EN`=0.
- `lock_s` is `LOCK_DET` passed through a 2-flop synchronizer.
- All outputs are registered. They are decoded from the next state so that they change on the same edge as `STATE`.

## Timing
- From the `EN` rise edge to `NRST_SUB` high is exactly max(`T_HOLD`,1)+1 cycles.
- `CAL_START` rises on the same edge as `NRST_SUB` and is high for exactly 1 cycle.
- From `CAL_DONE` being sampled high, `LOOP_EN` is high 1 cycle later.
- From a `LOCK_DET` rise to `READY` is 2 (synchronizer) + max(`T_LOCK`,1) cycles, provided `LOCK_DET` stays high.
- From a `LOCK_DET` fall while LOCKED, `READY` falls after 3 cycles.
- Mid-operation reset: asynchronous return to the reset values with no glitch-free guarantee. `CAL_START` must never be left high.
- The hold, qualify and timeout counters saturate and never wrap.

## Structure
- A shared package `pll_seq_pkg` holds:
  - the state encodings (`ST_IDLE` through `ST_FAIL`, 3 bits);
  - `TO_W`=16.
- One sub-module, `sync2_n`: a 2-flop synchronizer reset to 0 by `NARST`, used for `LOCK_DET`.
- The remainder is a single FSM with three counters.

## Test plan
- `T_HOLD`=5, `EN` raised at cycle 0, `CAL_DONE` at cycle 10, `LOCK_DET` high from cycle 12, `T_LOCK`=4:
  - `NRST_SUB` rises at cycle 6;
  - `CAL_START` pulses at cycle 6 only;
  - `LOOP_EN` rises at cycle 11;
  - `READY` rises at cycle 18.
- `T_HOLD`=0, `T_LOCK`=0: both behave as 1, so `NRST_SUB` rises 2 cycles after `EN`.
- `TO_CYC`=16 and `CAL_DONE` never arrives:
  - `FAIL`=1 and `STATE`=5 after 16 CAL cycles;
  - `LOOP_EN` stays 0;
  - `EN` low clears `FAIL` next cycle.
- `LOCK_DET` chatter (high 3, low 1, repeated) with `T_LOCK`=4:
  - `READY` never asserts;
  - `FAIL` asserts at the LOCKWAIT timeout.
- In LOCKED, `LOCK_DET` drops for 2 cycles:
  - `READY` falls 3 cycles later and `STATE`=3;
  - `LOOP_EN` stays 1;
  - no `CAL_START`;
  - `READY` returns after relock.
- `NARST` pulsed low during CAL:
  - all outputs are 0 immediately;
  - after release with `EN`=1, the full sequence restarts from HOLD.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared encodings for the PLL power-up / relock sequencer.
// STATE codes are visible on the debug port, so their values are fixed.
package pll_seq_pkg;

  localparam int TO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_CAL      = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

endpackage

// File: rtl/sync2_n.sv
// Two-flop synchronizer for the asynchronous lock detector.
// Both flops clear on NARST so lock_s reads 0 out of reset.
module sync2_n (
  input  logic clk,
  input  logic narst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge narst) begin
    if (!narst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_startup_seq.sv
// PLL start-up sequencer: sub-block reset hold, DCO calibration, loop close
// and lock qualification, with timeouts to a sticky FAIL state.
module pll_startup_seq
  import pll_seq_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int TO_CYC = 1023
) (
  input  logic             CLK,
  input  logic             NARST,
  input  logic             EN,
  input  logic [CNT_W-1:0] T_HOLD,
  input  logic [CNT_W-1:0] T_LOCK,
  input  logic             CAL_DONE,
  input  logic             LOCK_DET,
  output logic             NRST_SUB,
  output logic             CAL_START,
  output logic             LOOP_EN,
  output logic             READY,
  output logic             FAIL,
  output logic [2:0]       STATE
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] qual_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] hold_load;
  logic [CNT_W-1:0] lock_need;
  logic             lock_s;
  logic             to_hit;
  logic             qual_hit;

  sync2_n u_lock_sync (
    .clk  (CLK),
    .narst(NARST),
    .d    (LOCK_DET),
    .q    (lock_s)
  );

  assign hold_load = (T_HOLD == '0) ? CNT_ONE : T_HOLD;
  assign lock_need = (T_LOCK == '0) ? CNT_ONE : T_LOCK;
  assign to_hit    = (to_cnt >= TO_LAST);
  // Qualified on the cycle whose lock_s sample completes the required run.
  assign qual_hit  = lock_s && (qual_cnt >= (lock_need - CNT_ONE));

  // Calibration handshake: CAL_START is a one-cycle request issued on CAL
  // entry; CAL_DONE is a level acknowledge sampled every cycle while in CAL.
  always_comb begin
    state_nxt = state;
    if (!EN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_HOLD;
        ST_HOLD:     if (hold_cnt <= CNT_ONE) state_nxt = ST_CAL;
        ST_CAL: begin
          if (CAL_DONE)    state_nxt = ST_LOCKWAIT;
          else if (to_hit) state_nxt = ST_FAIL;
        end
        ST_LOCKWAIT: begin
          if (qual_hit)    state_nxt = ST_LOCKED;
          else if (to_hit) state_nxt = ST_FAIL;
        end
        ST_LOCKED:   if (!lock_s) state_nxt = ST_LOCKWAIT;
        ST_FAIL:     state_nxt = ST_FAIL;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      qual_cnt  <= '0;
      to_cnt    <= '0;
      NRST_SUB  <= 1'b0;
      CAL_START <= 1'b0;
      LOOP_EN   <= 1'b0;
      READY     <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && state_nxt == ST_HOLD)
        hold_cnt <= hold_load;
      else if (state == ST_HOLD && hold_cnt > CNT_ONE)
        hold_cnt <= hold_cnt - CNT_ONE;

      // Any state change restarts the timeout, covering CAL and LOCKWAIT entry.
      if (state_nxt != state)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TO_ONE;

      if (state != ST_LOCKWAIT || state_nxt != ST_LOCKWAIT || !lock_s)
        qual_cnt <= '0;
      else if (qual_cnt != CNT_MAX)
        qual_cnt <= qual_cnt + CNT_ONE;

      NRST_SUB  <= state_nxt inside {ST_CAL, ST_LOCKWAIT, ST_LOCKED, ST_FAIL};
      CAL_START <= (state_nxt == ST_CAL) && (state != ST_CAL);
      LOOP_EN   <= state_nxt inside {ST_LOCKWAIT, ST_LOCKED};
      READY     <= (state_nxt == ST_LOCKED);
      FAIL      <= (state_nxt == ST_FAIL);
    end
  end

  assign STATE = state;

endmodule
